// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// No timing of its own; the write-hit resolver is purely combinational.
package register_file_pkg;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Upper bound on write ports that the hit resolver can see.
  localparam int RF_MAX_WR = 8;

  // Highest-index write port that hits, or -1 when none does.
  function automatic int rf_wr_select(input logic [RF_MAX_WR-1:0] hits);
    int sel;
    sel = -1;
    for (int j = 0; j < RF_MAX_WR; j++) begin
      if (hits[j]) sel = j;
    end
    return sel;
  endfunction

endpackage

// File: rtl/register_file_mp_read_port.sv
// One registered read port: write-first bypass, zero-register mask, clear while sweeping.
// Latency 1 cycle; no backpressure, holds its data while the enable is low.
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int AW       = 4,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_mem_dat,
  input  logic             i_byp_vld,
  input  logic [WIDTH-1:0] i_byp_dat,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_rdata;
  logic             w_zero_hit;

  assign w_zero_hit = (ZERO_REG != 0) && (i_addr == '0);
  assign o_rdata    = r_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_en) begin
      if (w_zero_hit)     r_rdata <= '0;
      else if (i_byp_vld) r_rdata <= i_byp_dat;
      else                r_rdata <= i_mem_dat;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with clear sweep, write priority and read bypass.
// Read latency 1 cycle; no backpressure, ready is low for DEPTH cycles while the sweep runs.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 16,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_RD-1:0]       read_en,
  input  logic [NUM_RD*AW-1:0]    raddr,
  output logic [NUM_RD*WIDTH-1:0] rdata,
  input  logic [NUM_WR-1:0]       write_en,
  input  logic [NUM_WR*AW-1:0]    waddr,
  input  logic [NUM_WR*WIDTH-1:0] wdata,
  input  logic                    init_req,
  output logic                    ready
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  rf_state_t        r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_ready;
  logic             w_run;

  assign w_run = (r_state == RF_READY);
  assign ready = r_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        RF_INIT: begin
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= RF_READY;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (init_req) begin
            r_state <= RF_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  // Later loop iterations override earlier ones, so the highest write port wins.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (write_en[j] && !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0))) begin
          r_mem[waddr[j*AW +: AW]] <= wdata[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [RF_MAX_WR-1:0] w_hits;
    logic [WIDTH-1:0]     w_byp_dat;
    int                   w_sel;

    always_comb begin
      w_hits    = '0;
      w_byp_dat = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        w_hits[j] = w_run && write_en[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW]);
      end
      w_sel = rf_wr_select(w_hits);
      for (int j = 0; j < NUM_WR; j++) begin
        if (j == w_sel) w_byp_dat = wdata[j*WIDTH +: WIDTH];
      end
    end

    rf_read_port #(
      .WIDTH   (WIDTH),
      .AW      (AW),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_en     (w_run & read_en[i]),
      .i_clr    (!w_run),
      .i_addr   (raddr[i*AW +: AW]),
      .i_mem_dat(r_mem[raddr[i*AW +: AW]]),
      .i_byp_vld(|w_hits),
      .i_byp_dat(w_byp_dat),
      .o_rdata  (rdata[i*WIDTH +: WIDTH])
    );
  end

endmodule
